// File: rtl/xbus_fabric.sv
// ---------------------------------------------------------------------------
// xbus_fabric
//
// Interconnect between the core master port and NSLAVES xbus slaves.
// - Decodes the master address against a base/mask map. When several slaves
//   match, the lowest index wins.
// - Latches the request and holds it on the slave side until the selected
//   slave raises s_ready.
// - A watchdog aborts a slave that takes too long. TIMEOUT=0 turns it off.
// - The first error since the last clear is kept in a sticky register.
//
// Optional feature: define XBUS_FABRIC_PROT_EN to enable write protection.
// A write that hits a slave with RO_MASK[i]=1 is then rejected as a decode
// error. When the macro is undefined, RO_MASK has no effect.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   m_as/m_we/m_be/m_addr/m_wdata   master request (m_as held until m_ready)
//   m_rdata/m_ready/m_err  master response (m_ready is a 1-cycle pulse)
//   s_cs/s_we/s_be/s_addr/s_wdata   slave request (one-hot select, latched)
//   s_rdata/s_ready        packed slave read data / per-slave done
//   err_clr                clears err_valid
//   err_valid/err_addr     sticky error flag and address of the first error
// ---------------------------------------------------------------------------
module xbus_fabric #(
    parameter int                      NSLAVES  = 4,
    parameter logic [NSLAVES*32-1:0]   SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                                   32'h1000_0000, 32'h0000_0000},
    parameter logic [NSLAVES*32-1:0]   SLV_MASK = {4{32'hF000_0000}},
    parameter int                      TIMEOUT  = 255,
    parameter logic [NSLAVES-1:0]      RO_MASK  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m_as,
    input  logic                    m_we,
    input  logic [3:0]              m_be,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    output logic [31:0]             m_rdata,
    output logic                    m_ready,
    output logic                    m_err,
    output logic [NSLAVES-1:0]      s_cs,
    output logic                    s_we,
    output logic [3:0]              s_be,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    input  logic [NSLAVES*32-1:0]   s_rdata,
    input  logic [NSLAVES-1:0]      s_ready,
    input  logic                    err_clr,
    output logic                    err_valid,
    output logic [31:0]             err_addr
);

    localparam int IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    // The watchdog is disabled when TIMEOUT is 0. The timer keeps a
    // one-bit width in that case so that the declaration stays legal.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

`ifdef XBUS_FABRIC_PROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state;
    logic [TW-1:0]       timer;
    logic [IW-1:0]       sel;

    logic [NSLAVES-1:0]  hit;
    logic [NSLAVES-1:0]  sel_onehot;
    logic [IW-1:0]       sel_idx;
    logic                any_hit;
    logic                blocked;
    logic                accept;
    logic                timeout_hit;
    logic                err_event;
    logic [31:0]         err_addr_in;
    logic [31:0]         rdata_arr [NSLAVES];

    for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_slave
        assign hit[gi]       = (m_addr & SLV_MASK[gi*32 +: 32]) == SLV_BASE[gi*32 +: 32];
        assign rdata_arr[gi] = s_rdata[gi*32 +: 32];
    end

    // Priority encoder. The loop scans downwards, so the lowest matching
    // index is the last assignment and wins.
    always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        any_hit    = 1'b0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_idx       = IW'(i);
                any_hit       = 1'b1;
            end
        end
    end

    assign blocked     = PROT && m_we && (|(sel_onehot & RO_MASK));
    assign accept      = any_hit && !blocked;
    assign timeout_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

    // An error is either a decode or protection reject taken in IDLE, or a
    // watchdog abort taken in WAIT.
    assign err_event   = ((state == S_IDLE) && m_as && !accept) ||
                         ((state == S_WAIT) && !s_ready[sel] && timeout_hit);
    assign err_addr_in = (state == S_IDLE) ? m_addr : s_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            sel     <= '0;
            s_cs    <= '0;
            s_we    <= 1'b0;
            s_be    <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            m_rdata <= '0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (m_as) begin
                        if (accept) begin
                            state   <= S_WAIT;
                            sel     <= sel_idx;
                            s_cs    <= sel_onehot;
                            s_we    <= m_we;
                            s_be    <= m_be;
                            s_addr  <= m_addr;
                            s_wdata <= m_wdata;
                        end else begin
                            state   <= S_RESP;
                            m_ready <= 1'b1;
                            m_err   <= 1'b1;
                            m_rdata <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    if (s_ready[sel]) begin
                        state   <= S_RESP;
                        s_cs    <= '0;
                        m_ready <= 1'b1;
                        m_err   <= 1'b0;
                        m_rdata <= rdata_arr[sel];
                    end else if (timeout_hit) begin
                        state   <= S_RESP;
                        s_cs    <= '0;
                        m_ready <= 1'b1;
                        m_err   <= 1'b1;
                        m_rdata <= '0;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    timer <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                    s_cs  <= '0;
                end
            endcase
        end
    end

    // Sticky error capture. If a new error and err_clr arrive in the same
    // cycle, the new error wins and its address replaces the stored one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (err_event) begin
            err_valid <= 1'b1;
            if (!err_valid || err_clr) begin
                err_addr <= err_addr_in;
            end
        end else if (err_clr) begin
            err_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xbus_fabric.sv
// Testbench for xbus_fabric.
// The driver issues directed transactions and pushes the expected responses
// into a scoreboard queue. A monitor pops the queue and compares each
// m_ready pulse. A slave responder raises s_ready after a programmed number
// of wait cycles. It also records how long s_cs stays high and checks that
// the latched request holds steady while the slave is selected.
module tb_xbus_fabric;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m_as = 1'b0, m_we = 1'b0, err_clr = 1'b0;
    logic [3:0]    m_be = 4'h0;
    logic [31:0]   m_addr = '0, m_wdata = '0;
    logic [31:0]   m_rdata, s_addr, s_wdata, err_addr;
    logic          m_ready, m_err, s_we, err_valid;
    logic [3:0]    s_cs, s_be;
    logic [3:0]    s_ready = 4'h0;
    logic [127:0]  s_rdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_1234};

    always #5 clk = ~clk;

    xbus_fabric #(.NSLAVES(4), .TIMEOUT(16), .RO_MASK(4'b0001)) dut (
        .clk(clk), .rst(rst), .m_as(m_as), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
        .s_cs(s_cs), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .err_clr(err_clr),
        .err_valid(err_valid), .err_addr(err_addr)
    );

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        logic        ev;
        logic [31:0] ea;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    // Responder state. Only the driver writes these.
    int          wait_cfg = 0;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_be = '0;
    // Responder state. Only the responder writes these.
    int          cs_total = 0, bad_total = 0, wcount = 0;
    logic [3:0]  last_cs = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave responder.
    initial forever begin
        @(negedge clk);
        if (rst || s_cs == 4'b0000) begin
            wcount  = 0;
            s_ready = 4'b0000;
        end else begin
            cs_total++;
            last_cs = s_cs;
            if (s_addr !== exp_addr || s_we !== exp_we || s_be !== exp_be || s_wdata !== exp_wdata)
                bad_total++;
            if (wait_cfg >= 0 && wcount == wait_cfg) s_ready = s_cs;
            else                                     s_ready = 4'b0000;
            wcount++;
        end
    end

    // Scoreboard monitor.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (m_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: got m_ready=1 at cycle %0d expected no response", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_cycle"},     32'(cyc), 32'(e.cyc));
                check({e.name, "_rdata"},     m_rdata,   e.rdata);
                check({e.name, "_err"},       {31'b0, m_err},     {31'b0, e.err});
                check({e.name, "_err_valid"}, {31'b0, err_valid}, {31'b0, e.ev});
                check({e.name, "_err_addr"},  err_addr,  e.ea);
                $display("txn %-14s cycle=%0d rdata=%h err=%b err_valid=%b err_addr=%h",
                         e.name, cyc, m_rdata, m_err, err_valid, err_addr);
            end
        end
    end

    task automatic txn(input string name, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata, input int waits,
                       input logic hold, input logic clr,
                       input logic [3:0] e_cs, input int e_cs_cyc, input int e_lat,
                       input logic [31:0] e_rdata, input logic e_err,
                       input logic e_ev, input logic [31:0] e_ea);
        exp_t e;
        int   cs0, bad0;
        bit   got;
        @(posedge clk); #1;
        wait_cfg = waits; exp_addr = addr; exp_we = we; exp_be = be; exp_wdata = wdata;
        cs0 = cs_total; bad0 = bad_total;
        m_as = 1'b1; m_we = we; m_be = be; m_addr = addr; m_wdata = wdata; err_clr = clr;
        e.name = name; e.cyc = cyc + e_lat; e.rdata = e_rdata; e.err = e_err;
        e.ev = e_ev; e.ea = e_ea;
        sb.push_back(e);
        @(posedge clk); #1;
        err_clr = 1'b0;
        if (!hold) m_as = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (m_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_responded"}, {31'b0, got}, 32'd1);
        @(posedge clk); #1;
        m_as = 1'b0;
        check({name, "_cs_cycles"}, 32'(cs_total - cs0), 32'(e_cs_cyc));
        if (e_cs_cyc > 0) check({name, "_cs"}, {28'b0, last_cs}, {28'b0, e_cs});
        check({name, "_s_stable"}, 32'(bad_total - bad0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_ready", {31'b0, m_ready}, 32'd0);
        check("rst_s_cs", {28'b0, s_cs}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("init_m_err", {31'b0, m_err}, 32'd0);
        check("init_m_rdata", m_rdata, 32'd0);
        check("init_err_valid", {31'b0, err_valid}, 32'd0);
        check("init_err_addr", err_addr, 32'd0);
        check("init_s_addr", s_addr, 32'd0);

        //  name            addr           we  be       wdata         wt  hd clr  cs       ncs lat rdata          err ev  ea
        txn("rd_s1",        32'h1000_0004, 0, 4'hF,    32'h0,        0,  1, 0,  4'b0010, 1,  2,  32'hDEAD_BEEF, 0,  0,  32'h0);
        txn("wr_s2",        32'h2000_0000, 1, 4'b0001, 32'h0000_00A5, 5, 1, 0,  4'b0100, 6,  7,  32'h2222_2222, 0,  0,  32'h0);
        txn("rd_drop_as",   32'h1000_0000, 0, 4'hF,    32'h0,        3,  0, 0,  4'b0010, 4,  5,  32'hDEAD_BEEF, 0,  0,  32'h0);
        txn("rd_unmapped",  32'h5000_0000, 0, 4'hF,    32'h0,        0,  1, 0,  4'b0000, 0,  1,  32'h0,         1,  1,  32'h5000_0000);
        txn("rd_timeout",   32'h3000_0008, 0, 4'hF,    32'h0,        -1, 1, 0,  4'b1000, 16, 17, 32'h0,         1,  1,  32'h5000_0000);
        txn("err_clr_race", 32'h7000_0000, 0, 4'hF,    32'h0,        0,  1, 1,  4'b0000, 0,  1,  32'h0,         1,  1,  32'h7000_0000);

        // An err_clr pulse with no error present clears the flag and keeps the address.
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        check("clr_err_valid", {31'b0, err_valid}, 32'd0);
        check("clr_err_addr", err_addr, 32'h7000_0000);

        txn("wr_timeout",   32'h3000_0004, 1, 4'b1100, 32'h1111_2222, -1, 1, 0, 4'b1000, 16, 17, 32'h0,         1,  1,  32'h3000_0004);

        // Reset in the middle of a WAIT to slave 0. No response may follow.
        @(posedge clk); #1;
        wait_cfg = 3; exp_addr = 32'h20; exp_we = 1'b0; exp_be = 4'hF; exp_wdata = 32'h0;
        m_as = 1'b1; m_we = 1'b0; m_be = 4'hF; m_addr = 32'h20; m_wdata = 32'h0;
        @(posedge clk); #1; m_as = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_pre_cs", {28'b0, s_cs}, 32'b0001);
        #3 rst = 1'b1;
        #1;
        check("rst_mid_cs", {28'b0, s_cs}, 32'd0);
        check("rst_mid_ready", {31'b0, m_ready}, 32'd0);
        check("rst_mid_err_valid", {31'b0, err_valid}, 32'd0);
        check("rst_mid_err_addr", err_addr, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (6) @(posedge clk);

        txn("rd_after_rst", 32'h0000_0004, 0, 4'hF,    32'h0,        0,  1, 0,  4'b0001, 1,  2,  32'h0000_1234, 0,  0,  32'h0);
`ifdef XBUS_FABRIC_PROT_EN
        txn("prot_wr",      32'h0000_0010, 1, 4'hF,    32'hCAFE_F00D, 0, 1, 0,  4'b0000, 0,  1,  32'h0,         1,  1,  32'h0000_0010);
        txn("prot_rd",      32'h0000_0010, 0, 4'hF,    32'h0,        1,  1, 0,  4'b0001, 2,  3,  32'h0000_1234, 0,  1,  32'h0000_0010);
`else
        txn("prot_wr",      32'h0000_0010, 1, 4'hF,    32'hCAFE_F00D, 0, 1, 0,  4'b0001, 1,  2,  32'h0000_1234, 0,  0,  32'h0);
        txn("prot_rd",      32'h0000_0010, 0, 4'hF,    32'h0,        1,  1, 0,  4'b0001, 2,  3,  32'h0000_1234, 0,  0,  32'h0);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
